// File: rtl/shift_unit_seq.sv
// Multi-cycle shift unit: LSL / LSR / ASR / ROL with carry-out.
// Shifts at most STEP bits per BUSY cycle so the per-cycle barrel stays shallow.
// A valid/ready pair on each side; in_ready/out_valid decode from state only.
module shift_unit_seq #(
   parameter int DATA_WIDTH  = 20,
   parameter int SHIFT_WIDTH = 5,
   parameter int STEP        = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_WIDTH-1:0]  data_in,
   input  logic [SHIFT_WIDTH-1:0] shift_amount,
   input  logic [1:0]             mode,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_WIDTH-1:0]  data_out,
   output logic                   carry_out
);

   localparam int W = DATA_WIDTH;
   localparam logic [31:0] W32    = 32'(DATA_WIDTH);
   localparam logic [31:0] STEP32 = 32'(STEP);
   localparam logic [SHIFT_WIDTH-1:0] STEP_S = SHIFT_WIDTH'(STEP);

   localparam logic [1:0] M_LSL = 2'b00;
   localparam logic [1:0] M_LSR = 2'b01;
   localparam logic [1:0] M_ASR = 2'b10;
   localparam logic [1:0] M_ROL = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t                 state_q, state_d;
   logic [W-1:0]           data_q, data_d;
   logic                   carry_q, carry_d;
   logic [SHIFT_WIDTH-1:0] rem_q, rem_d;
   logic [1:0]             mode_q, mode_d;
   // LSL/LSR requested more than W bits: result is zero and carry is forced 0
   logic                   over_q, over_d;

   logic [31:0]            amt32;
   logic [SHIFT_WIDTH-1:0] eff;
   logic [SHIFT_WIDTH-1:0] step_s;
   logic [W-1:0]           step_res;
   logic                   step_c;
   logic [W:0]             lsl_ext;
   logic [W:0]             lsr_ext;
   logic signed [W:0]      asr_ext;
   logic [W-1:0]           rol_res;

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign data_out  = data_q;
   assign carry_out = carry_q;

   // Effective amount of the incoming request: ROL wraps, the others saturate at W
   always_comb begin
      amt32 = 32'(shift_amount);
      if (mode == M_ROL) eff = SHIFT_WIDTH'(amt32 % W32);
      else               eff = SHIFT_WIDTH'((amt32 > W32) ? W32 : amt32);
   end

   // One partial shift of up to STEP bits; the extra bit of each extended
   // vector catches the last bit pushed out, which becomes the carry
   always_comb begin
      step_s  = (32'(rem_q) < STEP32) ? rem_q : STEP_S;
      lsl_ext = {1'b0, data_q} << step_s;
      lsr_ext = {data_q, 1'b0} >> step_s;
      asr_ext = $signed({data_q, 1'b0}) >>> step_s;
      rol_res = (data_q << step_s) | (data_q >> (W32 - 32'(step_s)));
      step_res = data_q;
      step_c   = 1'b0;
      case (mode_q)
         M_LSL: begin step_res = lsl_ext[W-1:0]; step_c = lsl_ext[W]; end
         M_LSR: begin step_res = lsr_ext[W:1];   step_c = lsr_ext[0]; end
         M_ASR: begin step_res = asr_ext[W:1];   step_c = asr_ext[0]; end
         default: begin step_res = rol_res;      step_c = rol_res[0]; end
      endcase
   end

   // Next-state and datapath updates for IDLE -> BUSY -> DONE -> IDLE
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      carry_d = carry_q;
      rem_d   = rem_q;
      mode_d  = mode_q;
      over_d  = over_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               data_d  = data_in;
               mode_d  = mode;
               rem_d   = eff;
               carry_d = 1'b0;
               over_d  = ((mode == M_LSL) || (mode == M_LSR)) && (amt32 > W32);
               state_d = (eff == '0) ? S_DONE : S_BUSY;
            end
         end
         S_BUSY: begin
            data_d  = step_res;
            carry_d = step_c & ~over_q;
            rem_d   = rem_q - step_s;
            if (rem_q == step_s) state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register; reset drops any in-flight operation and clears the result
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         carry_q <= 1'b0;
         rem_q   <= '0;
         mode_q  <= M_LSL;
         over_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         carry_q <= carry_d;
         rem_q   <= rem_d;
         mode_q  <= mode_d;
         over_q  <= over_d;
      end
   end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Bench for shift_unit_seq: directed vector table, multi-cycle corner
// sequences (backpressure, reset mid-operation) and random ops vs. a bit-level model.
module tb_shift_unit_seq;

   localparam int W    = 20;
   localparam int SW   = 5;
   localparam int STEP = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  data_in;
   logic [SW-1:0] shift_amount;
   logic [1:0]    mode;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  data_out;
   logic          carry_out;

   int n_tests = 0;
   int n_fail  = 0;

   shift_unit_seq #(.DATA_WIDTH(W), .SHIFT_WIDTH(SW), .STEP(STEP)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .data_in(data_in), .shift_amount(shift_amount), .mode(mode),
      .out_valid(out_valid), .out_ready(out_ready),
      .data_out(data_out), .carry_out(carry_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] d;
      int           amt;
      int           md;
      logic [W-1:0] er;
      logic         ec;
      int           elat;
   } vec_t;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
      end
   endtask

   // Bit-by-bit reference built straight from the mode definitions
   task automatic model(input logic [W-1:0] d, input int amt, input int md,
                        output logic [W-1:0] r, output logic c, output int lat);
      int eff;
      eff = (md == 3) ? (amt % W) : ((amt > W) ? W : amt);
      lat = (eff + STEP - 1) / STEP;
      r = '0;
      c = 1'b0;
      for (int i = 0; i < W; i++) begin
         case (md)
            0: r[i] = (i - eff >= 0) ? d[i - eff] : 1'b0;
            1: r[i] = (i + eff < W) ? d[i + eff] : 1'b0;
            2: r[i] = (i + eff < W) ? d[i + eff] : d[W-1];
            default: r[(i + eff) % W] = d[i];
         endcase
      end
      if (md == 3) begin
         if (eff != 0) c = r[0];
      end else if (amt >= 1 && amt <= W) begin
         if (md == 0) c = d[W - eff];
         else         c = d[eff - 1];
      end else if (md == 2 && amt > W) begin
         c = d[W-1];
      end
   endtask

   // One request through the handshake: latency, result, hold-under-backpressure,
   // handoff; spam keeps in_valid high after acceptance to prove it is ignored
   task automatic run_op(input string nm, input logic [W-1:0] d, input int amt, input int md,
                         input logic [W-1:0] er, input logic ec, input int elat,
                         input int hold, input bit spam);
      int lat;
      @(negedge clk);
      check({nm, " in_ready before"}, 32'(in_ready), 32'd1);
      data_in = d; shift_amount = SW'(amt); mode = 2'(md); in_valid = 1'b1;
      @(negedge clk);
      if (spam) begin data_in = ~d; shift_amount = SW'(amt + 3); mode = 2'(md + 1); end
      else in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check({nm, " out_valid"}, 32'(out_valid), 32'd1);
      check({nm, " latency"},   32'(lat),       32'(elat));
      check({nm, " data"},      32'(data_out),  32'(er));
      check({nm, " carry"},     32'(carry_out), 32'(ec));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check({nm, " hold out_valid"}, 32'(out_valid), 32'd1);
         check({nm, " hold in_ready"},  32'(in_ready),  32'd0);
         check({nm, " hold data"},      32'(data_out),  32'(er));
         check({nm, " hold carry"},     32'(carry_out), 32'(ec));
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({nm, " post out_valid"}, 32'(out_valid), 32'd0);
      check({nm, " post in_ready"},  32'(in_ready),  32'd1);
      check({nm, " post data"},      32'(data_out),  32'(er));
      check({nm, " post carry"},     32'(carry_out), 32'(ec));
      in_valid = 1'b0;
   endtask

   vec_t tbl[14];

   initial begin
      logic [W-1:0] d, r;
      logic         c;
      int           amt, md, lat;

      tbl[0]  = '{20'hAAAAA, 3,  0, 20'h55550, 1'b1, 1};
      tbl[1]  = '{20'h8A8AA, 7,  2, 20'hFF151, 1'b0, 2};
      tbl[2]  = '{20'h8A8AA, 31, 1, 20'h00000, 1'b0, 5};
      tbl[3]  = '{20'h80000, 21, 3, 20'h00001, 1'b1, 1};
      tbl[4]  = '{20'h80000, 20, 3, 20'h80000, 1'b0, 0};
      tbl[5]  = '{20'h12345, 0,  0, 20'h12345, 1'b0, 0};
      tbl[6]  = '{20'h12345, 0,  1, 20'h12345, 1'b0, 0};
      tbl[7]  = '{20'h12345, 0,  2, 20'h12345, 1'b0, 0};
      tbl[8]  = '{20'h12345, 0,  3, 20'h12345, 1'b0, 0};
      tbl[9]  = '{20'h80000, 20, 2, 20'hFFFFF, 1'b1, 5};
      tbl[10] = '{20'h12345, 20, 0, 20'h00000, 1'b1, 5};
      tbl[11] = '{20'h12345, 25, 0, 20'h00000, 1'b0, 5};
      tbl[12] = '{20'h80000, 25, 2, 20'hFFFFF, 1'b1, 5};
      tbl[13] = '{20'h12345, 1,  1, 20'h091A2, 1'b1, 1};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      data_in = '0; shift_amount = '0; mode = '0;
      repeat (2) @(negedge clk);
      check("reset in_ready",  32'(in_ready),  32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset data",      32'(data_out),  32'd0);
      check("reset carry",     32'(carry_out), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 14; i++)
         run_op($sformatf("vec%0d", i), tbl[i].d, tbl[i].amt, tbl[i].md,
                tbl[i].er, tbl[i].ec, tbl[i].elat, 0, 1'b0);

      // Backpressure for 5 cycles with a competing request held high throughout
      run_op("backpressure", 20'hAAAAA, 3, 0, 20'h55550, 1'b1, 1, 5, 1'b1);
      run_op("after handoff", 20'h12345, 1, 1, 20'h091A2, 1'b1, 1, 0, 1'b0);

      // Reset in the middle of a 5-cycle BUSY run
      @(negedge clk);
      data_in = 20'h80000; shift_amount = 5'd20; mode = 2'd2; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst busy in_ready",  32'(in_ready),  32'd1);
      check("rst busy out_valid", 32'(out_valid), 32'd0);
      check("rst busy data",      32'(data_out),  32'd0);
      check("rst busy carry",     32'(carry_out), 32'd0);
      run_op("after rst busy", 20'h8A8AA, 7, 2, 20'hFF151, 1'b0, 2, 1, 1'b0);

      // Reset while a result is waiting in DONE
      @(negedge clk);
      data_in = 20'hAAAAA; shift_amount = 5'd3; mode = 2'd0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("done before rst", 32'(out_valid), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst done out_valid", 32'(out_valid), 32'd0);
      check("rst done data",      32'(data_out),  32'd0);
      check("rst done in_ready",  32'(in_ready),  32'd1);
      run_op("after rst done", 20'h80000, 21, 3, 20'h00001, 1'b1, 1, 0, 1'b0);

      // Random operations against the reference model
      for (int i = 0; i < 150; i++) begin
         d   = W'($urandom);
         amt = int'($urandom_range(0, 31));
         md  = int'($urandom_range(0, 3));
         model(d, amt, md, r, c, lat);
         run_op($sformatf("rnd%0d m%0d a%0d d%0h", i, md, amt, d), d, amt, md, r, c, lat,
                int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
